pic_interrupt_sequencer: RTL and testbench
==========================================

Name: pic_interrupt_sequencer

Overview:
Control sequencer that drives the 8259A priority resolver through the full interrupt-acknowledge cycle. It detects a resolved request, raises INT to the CPU, freezes the resolver during the first INTA pulse, and commits the winning IR into the in-service register. It drives the vector on the second INTA pulse and retires in-service bits on AEOI or on OCW2 EOI commands. It owns ISR_reg and feeds it, with freezing and resetedISR_index, back into the resolver.

Parameters:
NUM_IR, 8, number of interrupt lines; index width is 3, and only 8 is supported.

Ports:
clk  in  1  system clock; all state changes on rising edge
reset_n  in  1  asynchronous active-low reset
INT_request  in  1  resolver request, level
serviced_interrupt_index  in  3  resolver winning IR index
zeroLevelPriorityBit  in  3  resolver's current highest-priority IR, used for non-specific EOI
irr_pending  in  1  high while any unmasked IRR bit is set
INTA_n  in  1  CPU acknowledge, already synchronised to clk, active low
icw2_base  in  5  vector bits T7..T3
aeoi_mode  in  1  ICW4 AEOI enable
ocw2_wr  in  1  one-cycle strobe: OCW2 written
ocw2_data  in  8  OCW2 byte
INT  out  1  interrupt to CPU
freezing  out  1  resolver IRR freeze
INT_requestAck  out  1  toggles once per accepted request
ISR_reg  out  8  in-service register
resetedISR_index  out  3  index of last cleared ISR bit
data_out  out  8  vector byte
data_out_en  out  1  data bus drive enable
eoi_done  out  1  one-cycle pulse when an ISR bit is cleared

Behaviour:
- Reset (async, reset_n=0): state IDLE. INT=0, freezing=0, INT_requestAck=0, ISR_reg=0, resetedISR_index=0, data_out=0, data_out_en=0, eoi_done=0.
- Reset mid-cycle aborts the cycle immediately and drops all drives.
- INTA edges are detected on the registered previous INTA_n value: fall = prev 1, now 0; rise = prev 0, now 1.
- FSM states:
  - IDLE: on INT_request=1 -> PEND. On entry, set INT=1 and toggle INT_requestAck. Transition takes 1 cycle.
  - PEND: on INTA fall -> ACK1, with freezing=1 in the same edge.
  - ACK1: first INTA edge.
    - If irr_pending=1, latch serviced_interrupt_index into idx_q and set ISR_reg[idx_q].
    - If irr_pending=0, the request is spurious: idx_q=7 and the ISR bit is not set.
    - Deassert INT.
    - On INTA rise -> GAP.
  - GAP: freezing stays 1. On INTA fall -> ACK2.
  - ACK2: data_out={icw2_base, idx_q}, data_out_en=1 while INTA_n=0. On INTA rise:
    - data_out_en=0, freezing=0.
    - If aeoi_mode=1 and the request was not spurious, clear ISR_reg[idx_q], set resetedISR_index=idx_q, and pulse eoi_done.
    - -> IDLE.
- INTA fall while in IDLE is ignored, with no drive.
- INTA activity outside the PEND/ACK1/GAP/ACK2 sequence never sets the ISR.
- EOI handling on ocw2_wr, decoded from ocw2_data[7:5]. Accepted in any state.
  - 001 or 101 (non-specific): clear ISR bit zeroLevelPriorityBit+n for the lowest n in 0..7 (mod 8) with the bit set.
  - 011 or 111 (specific): clear ISR_reg[ocw2_data[2:0]] if it is set.
  - Any other code: no ISR change.
  - If a bit is cleared: resetedISR_index=that index and eoi_done=1 for one cycle.
  - If ISR is empty, or the specific bit is already 0: no change, no pulse.
- Simultaneous events:
  - ISR set (ACK1) and EOI clear in the same cycle on different bits: both apply.
  - Same bit: set wins, no eoi_done.
  - AEOI clear and OCW2 EOI in the same cycle: AEOI wins; the OCW2 EOI is dropped.
- A new INT_request seen while not in IDLE is held off; it is sampled again on return to IDLE.

Decomposition:
- Shared package pic_pkg holds:
  - the FSM state enum: IDLE, PEND, ACK1, GAP, ACK2;
  - OCW2 EOI code constants: EOI_NS=3'b001, EOI_SP=3'b011, ROT_NS=3'b101, ROT_SP=3'b111.
- One natural sub-module: pic_isr_eoi_unit.
  - Owns ISR_reg and implements set/clear arbitration, the non-specific rotating search and eoi_done.
  - The top holds the FSM, edge detect and vector mux.

Test Plan:
- Base 5'b01000, irr_pending=1, index 3, normal EOI: INT=1 one cycle after INT_request; freezing=1 from INTA1 fall; ISR_reg=8'h08; data_out=8'h43 during INTA2; INT_requestAck toggled once.
- AEOI=1, index 5: after INTA2 rise, ISR_reg=0, resetedISR_index=5, eoi_done one pulse, freezing=0.
- Spurious: irr_pending=0 at INTA1, base 5'b00010: ISR_reg unchanged, data_out=8'h17.
- ISR=8'h24, zeroLevelPriorityBit=4, OCW2=8'h20: bit 5 cleared -> ISR=8'h04, resetedISR_index=5. Then OCW2=8'h62: ISR=0, index 2.
- Assert reset_n=0 during GAP: all outputs return to reset values asynchronously; the next INT_request starts a clean sequence from IDLE.
- OCW2=8'h20 with ISR=0 and OCW2=8'h61 with ISR[1]=0: no eoi_done, ISR unchanged.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A interrupt-acknowledge sequencer.
package pic_pkg;
  localparam int NUM_IR = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [2:0] {IDLE, PEND, ACK1, GAP, ACK2} seq_state_t;

  localparam logic [2:0] EOI_NS = 3'b001;
  localparam logic [2:0] EOI_SP = 3'b011;
  localparam logic [2:0] ROT_NS = 3'b101;
  localparam logic [2:0] ROT_SP = 3'b111;
endpackage

// File: rtl/pic_interrupt_sequencer_if.sv
// Resolver, CPU-acknowledge and command-register signals seen by the sequencer.
interface pic_interrupt_sequencer_if;
  import pic_pkg::*;

  logic              INT_request;
  logic [IDX_W-1:0]  serviced_interrupt_index;
  logic [IDX_W-1:0]  zeroLevelPriorityBit;
  logic              irr_pending;
  logic              INTA_n;
  logic [4:0]        icw2_base;
  logic              aeoi_mode;
  logic              ocw2_wr;
  logic [7:0]        ocw2_data;
  logic              INT;
  logic              freezing;
  logic              INT_requestAck;
  logic [NUM_IR-1:0] ISR_reg;
  logic [IDX_W-1:0]  resetedISR_index;
  logic [7:0]        data_out;
  logic              data_out_en;
  logic              eoi_done;

  modport slave (
    input  INT_request, serviced_interrupt_index, zeroLevelPriorityBit, irr_pending,
           INTA_n, icw2_base, aeoi_mode, ocw2_wr, ocw2_data,
    output INT, freezing, INT_requestAck, ISR_reg, resetedISR_index,
           data_out, data_out_en, eoi_done
  );

  modport master (
    output INT_request, serviced_interrupt_index, zeroLevelPriorityBit, irr_pending,
           INTA_n, icw2_base, aeoi_mode, ocw2_wr, ocw2_data,
    input  INT, freezing, INT_requestAck, ISR_reg, resetedISR_index,
           data_out, data_out_en, eoi_done
  );
endinterface

// File: rtl/pic_isr_eoi_unit.sv
// In-service register: set from the acknowledge cycle, cleared by AEOI or OCW2 EOI,
// with a rotating lowest-distance search for non-specific EOI.
module pic_isr_eoi_unit
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [IDX_W-1:0]  set_idx,
  input  logic              aeoi_clr,
  input  logic [IDX_W-1:0]  aeoi_idx,
  input  logic              ocw2_wr,
  input  logic [7:0]        ocw2_data,
  input  logic [IDX_W-1:0]  zero_level,
  output logic [NUM_IR-1:0] isr,
  output logic [IDX_W-1:0]  cleared_idx,
  output logic              eoi_done
);
  logic [NUM_IR-1:0] isr_reg, isr_next, rot_isr;
  logic [IDX_W-1:0]  cleared_idx_reg, cleared_idx_next;
  logic              eoi_done_reg, eoi_done_next;
  logic              ns_found, ocw_clr, clr_en;
  logic [IDX_W-1:0]  ns_idx, ocw_idx, clr_idx;
  logic              unused_ocw2_bits;

  assign unused_ocw2_bits = ^ocw2_data[4:3];

  // rot_isr[n] is the ISR bit n positions above the current highest priority
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IR; gi++) begin : g_rot
      assign rot_isr[gi] = isr_reg[zero_level + IDX_W'(gi)];
    end
  endgenerate

  always_comb begin
    ns_found = 1'b0;
    ns_idx   = '0;
    for (int n = NUM_IR - 1; n >= 0; n--) begin
      if (rot_isr[n]) begin
        ns_found = 1'b1;
        ns_idx   = zero_level + IDX_W'(n);
      end
    end
  end

  always_comb begin
    ocw_clr = 1'b0;
    ocw_idx = ns_idx;
    if (ocw2_wr) begin
      case (ocw2_data[7:5])
        EOI_NS, ROT_NS: ocw_clr = ns_found;
        EOI_SP, ROT_SP: begin
          ocw_idx = ocw2_data[2:0];
          ocw_clr = isr_reg[ocw2_data[2:0]];
        end
        default: ocw_clr = 1'b0;
      endcase
    end
    // AEOI takes the clear slot outright; a concurrent OCW2 EOI is dropped
    clr_en  = aeoi_clr ? isr_reg[aeoi_idx] : ocw_clr;
    clr_idx = aeoi_clr ? aeoi_idx : ocw_idx;
    if (set_en && (clr_idx == set_idx)) clr_en = 1'b0;

    isr_next = isr_reg;
    if (clr_en) isr_next[clr_idx] = 1'b0;
    if (set_en) isr_next[set_idx] = 1'b1;
    eoi_done_next    = clr_en;
    cleared_idx_next = clr_en ? clr_idx : cleared_idx_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      isr_reg         <= '0;
      cleared_idx_reg <= '0;
      eoi_done_reg    <= 1'b0;
    end else begin
      isr_reg         <= isr_next;
      cleared_idx_reg <= cleared_idx_next;
      eoi_done_reg    <= eoi_done_next;
    end
  end

  assign isr         = isr_reg;
  assign cleared_idx = cleared_idx_reg;
  assign eoi_done    = eoi_done_reg;
endmodule

// File: rtl/pic_interrupt_sequencer.sv
// Interrupt-acknowledge sequencer: INT handshake, two-pulse INTA cycle, vector drive
// and resolver freeze; ISR bookkeeping lives in pic_isr_eoi_unit.
module pic_interrupt_sequencer
  import pic_pkg::*;
(
  input logic                         clk,
  input logic                         reset_n,
  pic_interrupt_sequencer_if.slave    bus
);
  seq_state_t       state_reg, state_next;
  logic             inta_prev_reg;
  logic             int_reg, int_next;
  logic             freezing_reg, freezing_next;
  logic             ack_reg, ack_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             spurious_reg, spurious_next;
  logic [7:0]       data_out_reg, data_out_next;
  logic             data_out_en_reg, data_out_en_next;
  logic             inta_fall, inta_rise, isr_set, aeoi_clr;
  logic [NUM_IR-1:0] isr_w;
  logic [IDX_W-1:0] cleared_idx_w;
  logic             eoi_done_w;

  assign inta_fall = inta_prev_reg & ~bus.INTA_n;
  assign inta_rise = ~inta_prev_reg & bus.INTA_n;

  always_comb begin
    state_next       = state_reg;
    int_next         = int_reg;
    freezing_next    = freezing_reg;
    ack_next         = ack_reg;
    idx_next         = idx_reg;
    spurious_next    = spurious_reg;
    data_out_next    = data_out_reg;
    data_out_en_next = data_out_en_reg;
    isr_set          = 1'b0;
    aeoi_clr         = 1'b0;
    case (state_reg)
      IDLE: if (bus.INT_request) begin
        state_next = PEND;
        int_next   = 1'b1;
        ack_next   = ~ack_reg;
      end
      PEND: if (inta_fall) begin
        state_next    = ACK1;
        freezing_next = 1'b1;
        int_next      = 1'b0;
        // No unmasked request left at INTA1: answer with the IR7 spurious vector
        if (bus.irr_pending) begin
          idx_next      = bus.serviced_interrupt_index;
          spurious_next = 1'b0;
          isr_set       = 1'b1;
        end else begin
          idx_next      = IDX_W'(NUM_IR - 1);
          spurious_next = 1'b1;
        end
      end
      ACK1: if (inta_rise) state_next = GAP;
      GAP: if (inta_fall) begin
        state_next       = ACK2;
        data_out_next    = {bus.icw2_base, idx_reg};
        data_out_en_next = 1'b1;
      end
      ACK2: if (inta_rise) begin
        state_next       = IDLE;
        data_out_en_next = 1'b0;
        freezing_next    = 1'b0;
        aeoi_clr         = bus.aeoi_mode & ~spurious_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      inta_prev_reg   <= 1'b1;
      int_reg         <= 1'b0;
      freezing_reg    <= 1'b0;
      ack_reg         <= 1'b0;
      idx_reg         <= '0;
      spurious_reg    <= 1'b0;
      data_out_reg    <= '0;
      data_out_en_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      inta_prev_reg   <= bus.INTA_n;
      int_reg         <= int_next;
      freezing_reg    <= freezing_next;
      ack_reg         <= ack_next;
      idx_reg         <= idx_next;
      spurious_reg    <= spurious_next;
      data_out_reg    <= data_out_next;
      data_out_en_reg <= data_out_en_next;
    end
  end

  pic_isr_eoi_unit u_isr (
    .clk         (clk),
    .reset_n     (reset_n),
    .set_en      (isr_set),
    .set_idx     (idx_next),
    .aeoi_clr    (aeoi_clr),
    .aeoi_idx    (idx_reg),
    .ocw2_wr     (bus.ocw2_wr),
    .ocw2_data   (bus.ocw2_data),
    .zero_level  (bus.zeroLevelPriorityBit),
    .isr         (isr_w),
    .cleared_idx (cleared_idx_w),
    .eoi_done    (eoi_done_w)
  );

  assign bus.INT              = int_reg;
  assign bus.freezing         = freezing_reg;
  assign bus.INT_requestAck   = ack_reg;
  assign bus.ISR_reg          = isr_w;
  assign bus.resetedISR_index = cleared_idx_w;
  assign bus.data_out         = data_out_reg;
  assign bus.data_out_en      = data_out_en_reg;
  assign bus.eoi_done         = eoi_done_w;
endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed scenarios for pic_interrupt_sequencer with hand-computed expectations.
module tb_pic_interrupt_sequencer;
  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  pic_interrupt_sequencer_if bus();

  pic_interrupt_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ocw2(input logic [7:0] d);
    bus.ocw2_data = d;
    bus.ocw2_wr   = 1'b1;
    tick();
    bus.ocw2_wr   = 1'b0;
  endtask

  task automatic do_ack(input logic [4:0] base, input logic [2:0] idx, input logic irr);
    bus.icw2_base = base;
    bus.serviced_interrupt_index = idx;
    bus.irr_pending = irr;
    bus.INT_request = 1'b1;
    tick();
    bus.INT_request = 1'b0;
    tick();
    bus.INTA_n = 1'b0; tick();
    bus.INTA_n = 1'b1; tick();
    bus.INTA_n = 1'b0; tick();
    bus.INTA_n = 1'b1; tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    vectors++;
    if ({bus.INT, bus.freezing, bus.INT_requestAck, bus.ISR_reg, bus.resetedISR_index,
         bus.data_out, bus.data_out_en, bus.eoi_done} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got INT=%b frz=%b ack=%b isr=%h idx=%0d dout=%h en=%b eoi=%b exp all 0",
               bus.INT, bus.freezing, bus.INT_requestAck, bus.ISR_reg, bus.resetedISR_index,
               bus.data_out, bus.data_out_en, bus.eoi_done);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    bus.icw2_base = 5'b01000; bus.serviced_interrupt_index = 3'd3; bus.irr_pending = 1'b1;
    bus.INT_request = 1'b1;
    tick();
    bus.INT_request = 1'b0;
    vectors++; if (bus.INT !== 1'b1) begin miscompares++; $display("FAIL normal_int: got %b exp 1", bus.INT); end
    vectors++; if (bus.INT_requestAck !== 1'b1) begin miscompares++; $display("FAIL normal_ack: got %b exp 1", bus.INT_requestAck); end
    vectors++; if (bus.freezing !== 1'b0) begin miscompares++; $display("FAIL normal_frz_pend: got %b exp 0", bus.freezing); end
    tick();
    bus.INTA_n = 1'b0; tick();
    vectors++; if (bus.freezing !== 1'b1) begin miscompares++; $display("FAIL normal_frz_inta1: got %b exp 1", bus.freezing); end
    vectors++; if (bus.ISR_reg !== 8'h08) begin miscompares++; $display("FAIL normal_isr: got %h exp 08", bus.ISR_reg); end
    vectors++; if (bus.INT !== 1'b0) begin miscompares++; $display("FAIL normal_int_drop: got %b exp 0", bus.INT); end
    bus.INTA_n = 1'b1; tick();
    vectors++; if (bus.freezing !== 1'b1 || bus.data_out_en !== 1'b0) begin miscompares++; $display("FAIL normal_gap: got frz=%b en=%b exp frz=1 en=0", bus.freezing, bus.data_out_en); end
    bus.INTA_n = 1'b0; tick();
    vectors++; if ({bus.data_out_en, bus.data_out} !== 9'h143) begin miscompares++; $display("FAIL normal_vector: got en=%b dout=%h exp en=1 dout=43", bus.data_out_en, bus.data_out); end
    bus.INTA_n = 1'b1; tick();
    vectors++; if ({bus.data_out_en, bus.freezing} !== 2'b00) begin miscompares++; $display("FAIL normal_release: got en=%b frz=%b exp 0 0", bus.data_out_en, bus.freezing); end
    vectors++; if (bus.ISR_reg !== 8'h08 || bus.eoi_done !== 1'b0) begin miscompares++; $display("FAIL normal_isr_hold: got isr=%h eoi=%b exp 08 0", bus.ISR_reg, bus.eoi_done); end
    vectors++; if (bus.INT_requestAck !== 1'b1) begin miscompares++; $display("FAIL normal_ack_once: got %b exp 1", bus.INT_requestAck); end
    ocw2(8'h63);
    vectors++; if ({bus.ISR_reg, bus.resetedISR_index, bus.eoi_done} !== {8'h00, 3'd3, 1'b1}) begin miscompares++; $display("FAIL normal_eoi: got isr=%h idx=%0d eoi=%b exp 00 3 1", bus.ISR_reg, bus.resetedISR_index, bus.eoi_done); end
    tick();
    vectors++; if (bus.eoi_done !== 1'b0) begin miscompares++; $display("FAIL normal_eoi_pulse: got %b exp 0", bus.eoi_done); end
  endtask

  task automatic test_aeoi();
    bus.aeoi_mode = 1'b1;
    bus.icw2_base = 5'b01000; bus.serviced_interrupt_index = 3'd5; bus.irr_pending = 1'b1;
    bus.INT_request = 1'b1; tick(); bus.INT_request = 1'b0;
    vectors++; if (bus.INT_requestAck !== 1'b0) begin miscompares++; $display("FAIL aeoi_ack_toggle: got %b exp 0", bus.INT_requestAck); end
    tick();
    bus.INTA_n = 1'b0; tick();
    vectors++; if (bus.ISR_reg !== 8'h20) begin miscompares++; $display("FAIL aeoi_isr_set: got %h exp 20", bus.ISR_reg); end
    bus.INTA_n = 1'b1; tick();
    bus.INTA_n = 1'b0; tick();
    vectors++; if (bus.data_out !== 8'h45) begin miscompares++; $display("FAIL aeoi_vector: got %h exp 45", bus.data_out); end
    bus.INTA_n = 1'b1; tick();
    vectors++; if ({bus.ISR_reg, bus.resetedISR_index, bus.eoi_done, bus.freezing} !== {8'h00, 3'd5, 1'b1, 1'b0}) begin miscompares++; $display("FAIL aeoi_clear: got isr=%h idx=%0d eoi=%b frz=%b exp 00 5 1 0", bus.ISR_reg, bus.resetedISR_index, bus.eoi_done, bus.freezing); end
    tick();
    vectors++; if (bus.eoi_done !== 1'b0) begin miscompares++; $display("FAIL aeoi_pulse: got %b exp 0", bus.eoi_done); end
    bus.aeoi_mode = 1'b0;
  endtask

  task automatic test_spurious();
    bus.icw2_base = 5'b00010; bus.serviced_interrupt_index = 3'd2; bus.irr_pending = 1'b0;
    bus.INT_request = 1'b1; tick(); bus.INT_request = 1'b0; tick();
    bus.INTA_n = 1'b0; tick();
    vectors++; if (bus.ISR_reg !== 8'h00 || bus.freezing !== 1'b1) begin miscompares++; $display("FAIL spur_inta1: got isr=%h frz=%b exp 00 1", bus.ISR_reg, bus.freezing); end
    bus.INTA_n = 1'b1; tick();
    bus.INTA_n = 1'b0; tick();
    vectors++; if ({bus.data_out_en, bus.data_out} !== 9'h117) begin miscompares++; $display("FAIL spur_vector: got en=%b dout=%h exp en=1 dout=17", bus.data_out_en, bus.data_out); end
    bus.INTA_n = 1'b1; tick();
    vectors++; if (bus.ISR_reg !== 8'h00 || bus.eoi_done !== 1'b0) begin miscompares++; $display("FAIL spur_end: got isr=%h eoi=%b exp 00 0", bus.ISR_reg, bus.eoi_done); end
    bus.irr_pending = 1'b1;
  endtask

  task automatic test_eoi_rotation();
    do_ack(5'b01000, 3'd2, 1'b1);
    do_ack(5'b01000, 3'd5, 1'b1);
    vectors++; if (bus.ISR_reg !== 8'h24) begin miscompares++; $display("FAIL rot_setup: got %h exp 24", bus.ISR_reg); end
    bus.zeroLevelPriorityBit = 3'd4;
    ocw2(8'h20);
    vectors++; if ({bus.ISR_reg, bus.resetedISR_index, bus.eoi_done} !== {8'h04, 3'd5, 1'b1}) begin miscompares++; $display("FAIL rot_ns: got isr=%h idx=%0d eoi=%b exp 04 5 1", bus.ISR_reg, bus.resetedISR_index, bus.eoi_done); end
    ocw2(8'h62);
    vectors++; if ({bus.ISR_reg, bus.resetedISR_index, bus.eoi_done} !== {8'h00, 3'd2, 1'b1}) begin miscompares++; $display("FAIL rot_sp: got isr=%h idx=%0d eoi=%b exp 00 2 1", bus.ISR_reg, bus.resetedISR_index, bus.eoi_done); end
    tick();
    do_ack(5'b01000, 3'd1, 1'b1);
    do_ack(5'b01000, 3'd6, 1'b1);
    bus.zeroLevelPriorityBit = 3'd7;
    ocw2(8'hA0);
    vectors++; if ({bus.ISR_reg, bus.resetedISR_index, bus.eoi_done} !== {8'h40, 3'd1, 1'b1}) begin miscompares++; $display("FAIL rot_wrap: got isr=%h idx=%0d eoi=%b exp 40 1 1", bus.ISR_reg, bus.resetedISR_index, bus.eoi_done); end
    bus.zeroLevelPriorityBit = 3'd4;
    ocw2(8'h20);
    vectors++; if ({bus.ISR_reg, bus.resetedISR_index} !== {8'h00, 3'd6}) begin miscompares++; $display("FAIL rot_last: got isr=%h idx=%0d exp 00 6", bus.ISR_reg, bus.resetedISR_index); end
    tick();
  endtask

  task automatic test_eoi_noop();
    ocw2(8'h20);
    vectors++; if ({bus.ISR_reg, bus.eoi_done, bus.resetedISR_index} !== {8'h00, 1'b0, 3'd6}) begin miscompares++; $display("FAIL noop_empty: got isr=%h eoi=%b idx=%0d exp 00 0 6", bus.ISR_reg, bus.eoi_done, bus.resetedISR_index); end
    do_ack(5'b01000, 3'd3, 1'b1);
    ocw2(8'h61);
    vectors++; if ({bus.ISR_reg, bus.eoi_done} !== {8'h08, 1'b0}) begin miscompares++; $display("FAIL noop_sp_clear_bit: got isr=%h eoi=%b exp 08 0", bus.ISR_reg, bus.eoi_done); end
    ocw2(8'h40);
    vectors++; if ({bus.ISR_reg, bus.eoi_done} !== {8'h08, 1'b0}) begin miscompares++; $display("FAIL noop_other_code: got isr=%h eoi=%b exp 08 0", bus.ISR_reg, bus.eoi_done); end
    ocw2(8'h63);
    vectors++; if (bus.ISR_reg !== 8'h00) begin miscompares++; $display("FAIL noop_cleanup: got %h exp 00", bus.ISR_reg); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_ack(5'b01000, 3'd2, 1'b1);
    // INTA1 set of bit 4 coincides with specific EOI of bit 2
    bus.serviced_interrupt_index = 3'd4;
    bus.INT_request = 1'b1; tick(); bus.INT_request = 1'b0; tick();
    bus.INTA_n = 1'b0; bus.ocw2_data = 8'h62; bus.ocw2_wr = 1'b1; tick(); bus.ocw2_wr = 1'b0;
    vectors++; if ({bus.ISR_reg, bus.resetedISR_index, bus.eoi_done} !== {8'h10, 3'd2, 1'b1}) begin miscompares++; $display("FAIL sim_diff_bits: got isr=%h idx=%0d eoi=%b exp 10 2 1", bus.ISR_reg, bus.resetedISR_index, bus.eoi_done); end
    bus.INTA_n = 1'b1; tick(); bus.INTA_n = 1'b0; tick(); bus.INTA_n = 1'b1; tick();
    // same bit: set wins
    bus.INT_request = 1'b1; tick(); bus.INT_request = 1'b0; tick();
    bus.INTA_n = 1'b0; bus.ocw2_data = 8'h64; bus.ocw2_wr = 1'b1; tick(); bus.ocw2_wr = 1'b0;
    vectors++; if ({bus.ISR_reg, bus.eoi_done} !== {8'h10, 1'b0}) begin miscompares++; $display("FAIL sim_same_bit: got isr=%h eoi=%b exp 10 0", bus.ISR_reg, bus.eoi_done); end
    bus.INTA_n = 1'b1; tick(); bus.INTA_n = 1'b0; tick(); bus.INTA_n = 1'b1; tick();
    // AEOI of bit 1 coincides with specific EOI of bit 4
    bus.aeoi_mode = 1'b1; bus.serviced_interrupt_index = 3'd1;
    bus.INT_request = 1'b1; tick(); bus.INT_request = 1'b0; tick();
    bus.INTA_n = 1'b0; tick();
    vectors++; if (bus.ISR_reg !== 8'h12) begin miscompares++; $display("FAIL sim_aeoi_set: got %h exp 12", bus.ISR_reg); end
    bus.INTA_n = 1'b1; tick(); bus.INTA_n = 1'b0; tick();
    bus.INTA_n = 1'b1; bus.ocw2_data = 8'h64; bus.ocw2_wr = 1'b1; tick(); bus.ocw2_wr = 1'b0;
    vectors++; if ({bus.ISR_reg, bus.resetedISR_index, bus.eoi_done} !== {8'h10, 3'd1, 1'b1}) begin miscompares++; $display("FAIL sim_aeoi_wins: got isr=%h idx=%0d eoi=%b exp 10 1 1", bus.ISR_reg, bus.resetedISR_index, bus.eoi_done); end
    bus.aeoi_mode = 1'b0;
    ocw2(8'h64);
    vectors++; if (bus.ISR_reg !== 8'h00) begin miscompares++; $display("FAIL sim_cleanup: got %h exp 00", bus.ISR_reg); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic ack_before;
    bus.icw2_base = 5'b01000; bus.serviced_interrupt_index = 3'd6; bus.irr_pending = 1'b1;
    bus.INT_request = 1'b1; tick(); bus.INT_request = 1'b0; tick();
    bus.INTA_n = 1'b0; tick(); bus.INTA_n = 1'b1; tick();
    vectors++; if ({bus.ISR_reg, bus.freezing} !== {8'h40, 1'b1}) begin miscompares++; $display("FAIL mid_gap: got isr=%h frz=%b exp 40 1", bus.ISR_reg, bus.freezing); end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.INT, bus.freezing, bus.INT_requestAck, bus.ISR_reg, bus.resetedISR_index,
         bus.data_out, bus.data_out_en, bus.eoi_done} !== 24'h0) begin
      miscompares++;
      $display("FAIL mid_async_reset: got INT=%b frz=%b ack=%b isr=%h idx=%0d dout=%h en=%b eoi=%b exp all 0",
               bus.INT, bus.freezing, bus.INT_requestAck, bus.ISR_reg, bus.resetedISR_index,
               bus.data_out, bus.data_out_en, bus.eoi_done);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    ack_before = bus.INT_requestAck;
    bus.serviced_interrupt_index = 3'd1;
    bus.INT_request = 1'b1; tick(); bus.INT_request = 1'b0;
    vectors++; if ({bus.INT, bus.INT_requestAck} !== {1'b1, ~ack_before}) begin miscompares++; $display("FAIL mid_restart_int: got INT=%b ack=%b exp 1 %b", bus.INT, bus.INT_requestAck, ~ack_before); end
    tick();
    bus.INTA_n = 1'b0; tick();
    vectors++; if (bus.ISR_reg !== 8'h02) begin miscompares++; $display("FAIL mid_restart_isr: got %h exp 02", bus.ISR_reg); end
    bus.INTA_n = 1'b1; tick(); bus.INTA_n = 1'b0; tick();
    vectors++; if ({bus.data_out_en, bus.data_out} !== 9'h141) begin miscompares++; $display("FAIL mid_restart_vector: got en=%b dout=%h exp en=1 dout=41", bus.data_out_en, bus.data_out); end
    bus.INTA_n = 1'b1; tick();
    ocw2(8'h61);
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    bus.INT_request = 1'b0;
    bus.serviced_interrupt_index = 3'd0;
    bus.zeroLevelPriorityBit = 3'd0;
    bus.irr_pending = 1'b0;
    bus.INTA_n = 1'b1;
    bus.icw2_base = 5'd0;
    bus.aeoi_mode = 1'b0;
    bus.ocw2_wr = 1'b0;
    bus.ocw2_data = 8'h00;
    test_reset();
    test_normal();
    test_aeoi();
    test_spurious();
    test_eoi_rotation();
    test_eoi_noop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
